rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two requesters:
  - the pipeline writeback stage (WB, normal priority owner);
  - the long-latency unit (LU: load-miss return / multi-cycle MDU), valid/ready handshake.
- Starvation guard guarantees LU forward progress by back-pressuring WB.
- Optional post-reset sequencer clears x1..x31 to zero before the pipeline is released.

Parameters:
- XLEN, 32, data width of the register file.
- AW, 5, register address width (2^AW registers).
- STARVE_LIMIT, 4, consecutive cycles LU may wait (lu_valid && !lu_ready) before it is forced; range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- wb_valid  in  1  WB write request.
- wb_addr  in  AW  WB destination register.
- wb_data  in  XLEN  WB write data.
- wb_ready  out  1  WB accepted this cycle; pipeline stalls WB when low.
- lu_valid  in  1  LU write request; held stable until accepted.
- lu_addr  in  AW  LU destination register.
- lu_data  in  XLEN  LU write data.
- lu_ready  out  1  LU accepted this cycle.
- rf_wen  out  1  register file write enable (registered).
- rf_addr  out  AW  register file write address (registered).
- rf_data  out  XLEN  register file write data (registered).
- init_busy  out  1  clear sequence in progress; pipeline holds fetch.

Behaviour:
- Reset values (rst_n sampled low at clk edge):
  - rf_wen=0, rf_addr=0, rf_data=0, starve_cnt=0, force_lu=0.
  - State=INIT when RF_INIT_CLEAR_EN is defined, else RUN.
- States:
  - INIT:
    - init_cnt runs 1..31.
    - Each cycle the port outputs rf_wen=1, rf_addr=init_cnt, rf_data=0.
    - wb_ready=0, lu_ready=0, init_busy=1.
    - After init_cnt=31 is issued, the next state is RUN.
  - RUN: init_busy=0; normal arbitration (below).
- Grant, combinational, RUN only:
  - wb_ready = !force_lu.
  - lu_ready = force_lu || !wb_valid.
  - WB wins any simultaneous request unless force_lu=1.
- Accepted write (valid && ready) is registered onto rf_* at the next edge: 1-cycle latency.
- Write to x0: accepted normally (handshake completes), but rf_wen=0 for that cycle.
- No grant in a cycle: rf_wen=0 next cycle; rf_addr/rf_data hold their previous values.
- Starvation counter (starve_cnt):
  - Width $clog2(STARVE_LIMIT+1).
  - Increments each RUN cycle with lu_valid && !lu_ready.
  - Clears on LU accept, or when lu_valid=0.
- force_lu:
  - Registered; set when starve_cnt reaches STARVE_LIMIT.
  - Cleared on the cycle LU is accepted.
- Boundary rules:
  - With force_lu=1 and lu_valid dropped (illegal), force_lu clears and an assertion fires.
  - Reset mid-INIT or mid-forced-grant: all state returns to reset values and a pending LU request is not granted in the reset cycle.
  - Simultaneous WB and LU writes to the same register never occur; only one is granted per cycle.
- Assertions:
  - At most one accept per cycle.
  - lu_addr/lu_data stable while lu_valid && !lu_ready.

Optional Feature:
- Macro: RF_INIT_CLEAR_EN.
- Defined: INIT state present; 31-cycle zero-fill after every reset, init_busy high throughout.
- Undefined: INIT logic and init_cnt removed; reset goes directly to RUN; init_busy tied 0.
- Undefined also means register contents after reset are undefined except x0.

Decomposition:
- Package rf_pkg:
  - XLEN, AW, NUM_REGS=32 constants.
  - typedef enum logic {INIT, RUN} rf_arb_state_t.
  - typedef struct packed {logic wen; logic [AW-1:0] addr; logic [XLEN-1:0] data;} rf_wr_t.
- One sub-module, rf_starve_ctr:
  - Saturating counter with set/clear that produces force_lu.
  - Parameterised by STARVE_LIMIT.

Test Plan:
- Reset with RF_INIT_CLEAR_EN, then release:
  - init_busy=1 for exactly 31 cycles.
  - rf_addr steps 1..31 with rf_data=0.
  - wb_ready=lu_ready=0 throughout, then RUN.
- WB only: wb_valid=1, addr=5, data=0xDEADBEEF -> next cycle rf_wen=1, rf_addr=5, rf_data=0xDEADBEEF.
- Simultaneous WB (addr 3) and LU (addr 7):
  - WB granted, lu_ready=0.
  - Next cycle with wb_valid=0: LU granted, rf_addr=7 one cycle later.
- Continuous wb_valid, lu_valid=1, STARVE_LIMIT=4:
  - lu_ready low 4 cycles, then force_lu.
  - Cycle 5: wb_ready=0, lu_ready=1, LU write appears.
  - Cycle 6: wb_ready=1 again.
- Write to x0 from WB: handshake completes and rf_wen=0 next cycle.
- rst_n low for one cycle during INIT (init_cnt=12) and during force_lu=1 -> all outputs return to reset values and INIT restarts at 1.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file write-port arbiter.
//   XLEN     : register data width
//   AW       : register address width
//   NUM_REGS : number of architectural registers (x0 hard-wired to zero)
//   rf_arb_state_t : arbiter state (INIT = zero-fill sequence, RUN = arbitration)
//   rf_wr_t        : one registered write-port transaction
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        INIT,
        RUN
    } rf_arb_state_t;

    typedef struct packed {
        logic            wen;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_starve_ctr.sv
// -----------------------------------------------------------------------------
// rf_starve_ctr
// Saturating wait counter for the long-latency unit (LU). Counts RUN cycles in
// which LU requests but is not accepted; raises force_lu so that LU wins the
// following cycle once it has waited STARVE_LIMIT cycles.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   run      in   arbiter is in RUN (counting enabled)
//   req      in   LU request (lu_valid)
//   accept   in   LU accepted this cycle (lu_valid && lu_ready)
//   force_lu out  registered: LU must be granted this cycle
// -----------------------------------------------------------------------------
module rf_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic req,
    input  logic accept,
    output logic force_lu
);

    localparam int unsigned     CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            force_lu   <= 1'b0;
        end else if (run) begin
            if (accept || !req) begin
                starve_cnt <= '0;
                force_lu   <= 1'b0;
            end else begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
                // force_lu rises on the same edge the count reaches LIMIT,
                // so LU wins the cycle right after its LIMIT-th wait.
                if (starve_cnt >= LIMIT - 1'b1) begin
                    force_lu <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Owns the single write port of the register file. The writeback stage (WB)
// normally wins; the long-latency unit (LU) takes free cycles and is forced
// through by the starvation guard after STARVE_LIMIT consecutive waits.
// Accepted writes appear on rf_* one cycle later; writes to x0 complete the
// handshake but do not assert rf_wen.
//
// Build option RF_INIT_CLEAR_EN: when defined, every reset is followed by a
// 31-cycle INIT sequence writing zero to x1..x31 while init_busy is high and
// both requesters are held off. When undefined, reset goes straight to RUN and
// init_busy is tied low.
//
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   wb_valid/addr/data      WB write request
//   wb_ready                WB accepted this cycle
//   lu_valid/addr/data      LU write request (held until accepted)
//   lu_ready                LU accepted this cycle
//   rf_wen/addr/data        registered register-file write port
//   init_busy               zero-fill sequence in progress
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int unsigned XLEN         = rf_pkg::XLEN,
    parameter int unsigned AW           = rf_pkg::AW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lu_valid,
    input  logic [AW-1:0]   lu_addr,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_data,
    output logic            init_busy
);

    import rf_pkg::*;

    rf_arb_state_t state;
    logic          run;
    logic          force_lu;
    logic          wb_acc;
    logic          lu_acc;
    rf_wr_t        wr_q;
    rf_wr_t        wr_d;

`ifdef RF_INIT_CLEAR_EN
    rf_arb_state_t state_d;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] init_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= AW'(1);
        end else begin
            state    <= state_d;
            init_cnt <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        init_cnt_d = init_cnt;
        if (state == INIT) begin
            if (init_cnt == '1) begin
                state_d = RUN;
            end else begin
                init_cnt_d = init_cnt + 1'b1;
            end
        end
    end

    assign init_busy = (state == INIT);
`else
    assign state     = RUN;
    assign init_busy = 1'b0;
`endif

    // Grants are masked while rst_n is low so a pending LU request can never
    // complete its handshake in the reset cycle.
    assign run      = rst_n && (state == RUN);
    assign wb_ready = run && !force_lu;
    assign lu_ready = run && (force_lu || !wb_valid);
    assign wb_acc   = wb_valid && wb_ready;
    assign lu_acc   = lu_valid && lu_ready;

    rf_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .req      (lu_valid),
        .accept   (lu_acc),
        .force_lu (force_lu)
    );

    // Idle cycles drop rf_wen but keep the last address/data on the port.
    always_comb begin
        wr_d      = wr_q;
        wr_d.wen  = 1'b0;
        if (wb_acc) begin
            wr_d.wen  = (wb_addr != '0);
            wr_d.addr = wb_addr;
            wr_d.data = wb_data;
        end else if (lu_acc) begin
            wr_d.wen  = (lu_addr != '0);
            wr_d.addr = lu_addr;
            wr_d.data = lu_data;
        end
`ifdef RF_INIT_CLEAR_EN
        if (state == INIT) begin
            wr_d.wen  = 1'b1;
            wr_d.addr = init_cnt;
            wr_d.data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
        end else begin
            wr_q <= wr_d;
        end
    end

    assign rf_wen  = wr_q.wen;
    assign rf_addr = wr_q.addr;
    assign rf_data = wr_q.data;

    a_one_accept : assert property (@(posedge clk) disable iff (!rst_n)
        !(wb_acc && lu_acc));

    a_lu_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (lu_valid && !lu_ready) |=> (lu_valid && $stable(lu_addr) && $stable(lu_data)));

    a_force_needs_req : assert property (@(posedge clk) disable iff (!rst_n)
        force_lu |-> lu_valid);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed self-checking bench for rf_write_arbiter with STARVE_LIMIT=4.
// Inputs change and outputs are sampled 1-2 time units after the falling edge.
// The INIT-sequence checks are only present when RF_INIT_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_wen;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        init_busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    rf_write_arbiter #(
        .XLEN         (32),
        .AW           (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .lu_valid  (lu_valid),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .rf_wen    (rf_wen),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .init_busy (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_wen"},  32'(rf_wen),  32'd0);
        check({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
        check({tag, "_rf_data"}, rf_data,      32'd0);
    endtask

    // Walks the zero-fill sequence starting in its first cycle; stops inside
    // the cycle where init_cnt == stop_at, or runs into the first RUN cycle
    // when stop_at is 31.
    task automatic run_init(input int unsigned stop_at);
`ifdef RF_INIT_CLEAR_EN
        for (int unsigned k = 1; k <= stop_at; k++) begin
            check("init_busy",    32'(init_busy), 32'd1);
            check("init_wb_rdy",  32'(wb_ready),  32'd0);
            check("init_lu_rdy",  32'(lu_ready),  32'd0);
            if (k > 1) begin
                check("init_rf_wen",  32'(rf_wen),  32'd1);
                check("init_rf_addr", 32'(rf_addr), 32'(k - 1));
                check("init_rf_data", rf_data,      32'd0);
            end
            if (k < stop_at) tick();
        end
        if (stop_at == 31) begin
            tick();
            check("init_done_busy", 32'(init_busy), 32'd0);
            check("init_last_addr", 32'(rf_addr),   32'd31);
            check("init_last_wen",  32'(rf_wen),    32'd1);
        end
`else
        if (stop_at == 0) check("init_busy_tied", 32'(init_busy), 32'd0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        lu_valid = 1'b0;
        lu_addr  = '0;
        lu_data  = '0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        check("rst_wb_rdy", 32'(wb_ready),  32'd0);
        check("rst_lu_rdy", 32'(lu_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        run_init(31);
        check("run_busy", 32'(init_busy), 32'd0);

        // WB alone
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        check("wb_only_wb_rdy", 32'(wb_ready), 32'd1);
        check("wb_only_lu_rdy", 32'(lu_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("wb_only_wen",  32'(rf_wen),  32'd1);
        check("wb_only_addr", 32'(rf_addr), 32'd5);
        check("wb_only_data", rf_data,      32'hDEADBEEF);
        tick();
        check("idle_wen",  32'(rf_wen),  32'd0);
        check("idle_addr", 32'(rf_addr), 32'd5);
        check("idle_data", rf_data,      32'hDEADBEEF);

        // Simultaneous WB and LU: WB first, LU on the following free cycle
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_0003;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h7777_0007;
        #1;
        check("both_wb_rdy", 32'(wb_ready), 32'd1);
        check("both_lu_rdy", 32'(lu_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("both_wb_addr", 32'(rf_addr), 32'd3);
        check("both_wb_data", rf_data,      32'h3333_0003);
        check("lu_free_rdy",  32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        check("lu_wen",  32'(rf_wen),  32'd1);
        check("lu_addr", 32'(rf_addr), 32'd7);
        check("lu_data", rf_data,      32'h7777_0007);

        // Starvation: WB streams, LU waits 4 cycles then is forced
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9999_0009;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = 5'(10 + i); wb_data = 32'(i);
            #1;
            check("starve_lu_rdy", 32'(lu_ready), 32'd0);
            check("starve_wb_rdy", 32'(wb_ready), 32'd1);
            if (i > 0) check("starve_wb_addr", 32'(rf_addr), 32'(9 + i));
            tick();
        end
        wb_addr = 5'd14; wb_data = 32'h0000_0014;
        #1;
        check("force_wb_rdy", 32'(wb_ready), 32'd0);
        check("force_lu_rdy", 32'(lu_ready), 32'd1);
        check("force_prev_addr", 32'(rf_addr), 32'd13);
        tick();
        lu_valid = 1'b0;
        #1;
        check("force_lu_wen",  32'(rf_wen),  32'd1);
        check("force_lu_addr", 32'(rf_addr), 32'd9);
        check("force_lu_data", rf_data,      32'h9999_0009);
        check("after_force_wb_rdy", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("stalled_wb_addr", 32'(rf_addr), 32'd14);
        check("stalled_wb_data", rf_data,      32'h0000_0014);

        // Write to x0
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
        #1;
        check("x0_wb_rdy", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("x0_wen", 32'(rf_wen), 32'd0);

`ifdef RF_INIT_CLEAR_EN
        // Reset in the middle of the zero-fill
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        run_init(12);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_init_rst");
        rst_n = 1'b1;
        #1;
        run_init(31);
`endif

        // Reset while LU is being forced
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h2222_0002;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'hAAAA_0009;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_force", 32'(lu_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_cycle_lu_rdy", 32'(lu_ready), 32'd0);
        check("rst_cycle_wb_rdy", 32'(wb_ready), 32'd0);
        tick();
        check_reset_outputs("force_rst");
        rst_n = 1'b1;
        #1;
        run_init(31);
        check("post_rst_lu_rdy", 32'(lu_ready), 32'd0);
        check("post_rst_wb_rdy", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        #1;
        check("post_rst_lu_free", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        check("post_rst_lu_addr", 32'(rf_addr), 32'd9);
        check("post_rst_lu_data", rf_data,      32'hAAAA_0009);
        check("post_rst_lu_wen",  32'(rf_wen),  32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
